// File: rtl/wasm_alu_int_mc.sv
// WebAssembly i32/i64 integer ALU: registered single-cycle ops plus an iterative radix-2 restoring divider.
// Optional build macro WASM_ALU_DIV_EARLY_OUT_EN enables divider early-out and leading-zero skipping.

package wasm_pkg;
    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_MUL    = 5'd2,
        OP_DIV_S  = 5'd3,
        OP_DIV_U  = 5'd4,
        OP_REM_S  = 5'd5,
        OP_REM_U  = 5'd6,
        OP_AND    = 5'd7,
        OP_OR     = 5'd8,
        OP_XOR    = 5'd9,
        OP_SHL    = 5'd10,
        OP_SHR_S  = 5'd11,
        OP_SHR_U  = 5'd12,
        OP_ROTL   = 5'd13,
        OP_ROTR   = 5'd14,
        OP_CLZ    = 5'd15,
        OP_CTZ    = 5'd16,
        OP_POPCNT = 5'd17,
        OP_EQZ    = 5'd18,
        OP_EQ     = 5'd19,
        OP_NE     = 5'd20,
        OP_LT_S   = 5'd21,
        OP_LT_U   = 5'd22,
        OP_GT_S   = 5'd23,
        OP_GT_U   = 5'd24,
        OP_LE_S   = 5'd25,
        OP_LE_U   = 5'd26,
        OP_GE_S   = 5'd27,
        OP_GE_U   = 5'd28
    } alu_op_t;

    typedef enum logic [1:0] {
        TRAP_NONE         = 2'd0,
        TRAP_INT_DIV_ZERO = 2'd1,
        TRAP_INT_OVERFLOW = 2'd2
    } trap_t;
endpackage

module wasm_alu_int_mc
    import wasm_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             valid_in,
    output logic             ready_in,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [WIDTH-1:0] result,
    output trap_t            trap,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  div_rem, div_quo, div_dvs;
    logic              neg_q, neg_r, is_rem;

    logic                     accept;
    logic signed [WIDTH-1:0]  sa, sb;
    logic [SH_W-1:0]          sh;
    logic [WIDTH-1:0]         alu_res;
    logic                     is_div, op_signed, op_rem;
    logic [WIDTH-1:0]         mag_a, mag_b;
    logic                     b_zero, min_neg1, early, go_div;
    logic [WIDTH-1:0]         early_res, quo_init;
    logic [CNT_W-1:0]         cnt_init;
    logic [WIDTH-1:0]         imm_res;
    trap_t                    imm_trap;
    logic [WIDTH:0]           trial;
    logic                     q_bit;
    logic [WIDTH-1:0]         rem_nxt, quo_nxt, fin_res;

    function automatic logic [WIDTH-1:0] f_clz(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        n = WIDTH'(WIDTH);
        for (int i = 0; i < WIDTH; i++)
            if (v[i]) n = WIDTH'(WIDTH - 1 - i);
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] f_ctz(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        n = WIDTH'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--)
            if (v[i]) n = WIDTH'(i);
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] f_popcnt(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++)
            n = n + WIDTH'(v[i]);
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] f_rotl(input logic [WIDTH-1:0] v, input logic [SH_W-1:0] s);
        logic [2*WIDTH-1:0] t;
        t = {v, v} << s;
        return t[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] f_rotr(input logic [WIDTH-1:0] v, input logic [SH_W-1:0] s);
        logic [2*WIDTH-1:0] t;
        t = {v, v} >> s;
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign ready_in = (state == S_IDLE) || (state == S_DONE && ready_out);
    assign accept   = valid_in && ready_in && !flush;
    assign sa       = operand_a;
    assign sb       = operand_b;
    assign sh       = operand_b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:    alu_res = operand_a + operand_b;
            OP_SUB:    alu_res = operand_a - operand_b;
            OP_MUL:    alu_res = operand_a * operand_b;
            OP_AND:    alu_res = operand_a & operand_b;
            OP_OR:     alu_res = operand_a | operand_b;
            OP_XOR:    alu_res = operand_a ^ operand_b;
            OP_SHL:    alu_res = operand_a << sh;
            OP_SHR_S:  alu_res = sa >>> sh;
            OP_SHR_U:  alu_res = operand_a >> sh;
            OP_ROTL:   alu_res = f_rotl(operand_a, sh);
            OP_ROTR:   alu_res = f_rotr(operand_a, sh);
            OP_CLZ:    alu_res = f_clz(operand_a);
            OP_CTZ:    alu_res = f_ctz(operand_a);
            OP_POPCNT: alu_res = f_popcnt(operand_a);
            OP_EQZ:    alu_res = WIDTH'(operand_a == '0);
            OP_EQ:     alu_res = WIDTH'(operand_a == operand_b);
            OP_NE:     alu_res = WIDTH'(operand_a != operand_b);
            OP_LT_S:   alu_res = WIDTH'(sa < sb);
            OP_LT_U:   alu_res = WIDTH'(operand_a < operand_b);
            OP_GT_S:   alu_res = WIDTH'(sa > sb);
            OP_GT_U:   alu_res = WIDTH'(operand_a > operand_b);
            OP_LE_S:   alu_res = WIDTH'(sa <= sb);
            OP_LE_U:   alu_res = WIDTH'(operand_a <= operand_b);
            OP_GE_S:   alu_res = WIDTH'(sa >= sb);
            OP_GE_U:   alu_res = WIDTH'(operand_a >= operand_b);
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        is_div    = 1'b0;
        op_signed = 1'b0;
        op_rem    = 1'b0;
        case (op)
            OP_DIV_S: begin is_div = 1'b1; op_signed = 1'b1; end
            OP_DIV_U: is_div = 1'b1;
            OP_REM_S: begin is_div = 1'b1; op_signed = 1'b1; op_rem = 1'b1; end
            OP_REM_U: begin is_div = 1'b1; op_rem = 1'b1; end
            default: ;
        endcase
    end

    assign mag_a    = f_mag(operand_a, op_signed);
    assign mag_b    = f_mag(operand_b, op_signed);
    assign b_zero   = (operand_b == '0);
    assign min_neg1 = op_signed && (operand_a == MIN_INT) && (operand_b == '1);

`ifdef WASM_ALU_DIV_EARLY_OUT_EN
    logic [WIDTH-1:0] lz_a;

    // Pre-align the dividend so only its significant bits are iterated.
    always_comb begin
        lz_a      = f_clz(mag_a);
        early     = (!op_signed && (operand_a < operand_b)) || (mag_a == '0);
        early_res = op_rem ? operand_a : '0;
        quo_init  = mag_a << lz_a;
        cnt_init  = CNT_W'(WIDTH) - CNT_W'(lz_a);
    end
`else
    always_comb begin
        early     = 1'b0;
        early_res = '0;
        quo_init  = mag_a;
        cnt_init  = CNT_W'(WIDTH);
    end
`endif

    assign go_div = is_div && !b_zero && !min_neg1 && !early;

    always_comb begin
        imm_res  = alu_res;
        imm_trap = TRAP_NONE;
        if (is_div) begin
            imm_res = '0;
            if (b_zero)
                imm_trap = TRAP_INT_DIV_ZERO;
            else if (min_neg1 && !op_rem)
                imm_trap = TRAP_INT_OVERFLOW;
            else if (early)
                imm_res = early_res;
        end
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign trial   = {div_rem, div_quo[WIDTH-1]};
    assign q_bit   = (trial >= {1'b0, div_dvs});
    assign rem_nxt = q_bit ? WIDTH'(trial - {1'b0, div_dvs}) : trial[WIDTH-1:0];
    assign quo_nxt = {div_quo[WIDTH-2:0], q_bit};
    assign fin_res = is_rem ? (neg_r ? -rem_nxt : rem_nxt)
                            : (neg_q ? -quo_nxt : quo_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            valid_out <= 1'b0;
            result    <= '0;
            trap      <= TRAP_NONE;
            busy      <= 1'b0;
            cnt       <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (go_div) begin
                            state     <= S_DIV;
                            valid_out <= 1'b0;
                            busy      <= 1'b1;
                            cnt       <= cnt_init;
                        end else begin
                            state     <= S_DONE;
                            valid_out <= 1'b1;
                            result    <= imm_res;
                            trap      <= imm_trap;
                        end
                    end else if (state == S_DONE && ready_out) begin
                        state     <= S_IDLE;
                        valid_out <= 1'b0;
                    end
                end
                S_DIV: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= S_DONE;
                        valid_out <= 1'b1;
                        busy      <= 1'b0;
                        result    <= fin_res;
                        trap      <= TRAP_NONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Divider datapath carries no reset; it is always reloaded on accept.
    always_ff @(posedge clk) begin
        if (accept && go_div) begin
            div_rem <= '0;
            div_quo <= quo_init;
            div_dvs <= mag_b;
            neg_q   <= op_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            neg_r   <= op_signed && operand_a[WIDTH-1];
            is_rem  <= op_rem;
        end else if (state == S_DIV) begin
            div_rem <= rem_nxt;
            div_quo <= quo_nxt;
        end
    end

endmodule

// File: tb/tb_wasm_alu_int_mc.sv
// Bench for wasm_alu_int_mc: 32- and 64-bit instances, vector table, random ops against a reference model, handshake corners.

module tb_wasm_alu_int_mc;
    import wasm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, ready_out;
    logic        v32, v64;
    alu_op_t     op;
    logic [63:0] a, b;

    logic        ri32, vo32, busy32;
    logic [31:0] res32;
    trap_t       trap32;
    logic        ri64, vo64, busy64;
    logic [63:0] res64;
    trap_t       trap64;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    wasm_alu_int_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(v32), .ready_in(ri32),
        .op(op), .operand_a(a[31:0]), .operand_b(b[31:0]), .valid_out(vo32),
        .ready_out(ready_out), .result(res32), .trap(trap32), .busy(busy32)
    );

    wasm_alu_int_mc #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(v64), .ready_in(ri64),
        .op(op), .operand_a(a), .operand_b(b), .valid_out(vo64),
        .ready_out(ready_out), .result(res64), .trap(trap64), .busy(busy64)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic get_ri(input int w);   return (w == 32) ? ri32 : ri64;     endfunction
    function automatic logic get_vo(input int w);   return (w == 32) ? vo32 : vo64;     endfunction
    function automatic logic get_busy(input int w); return (w == 32) ? busy32 : busy64; endfunction
    function automatic logic [63:0] get_res(input int w);
        return (w == 32) ? {32'd0, res32} : res64;
    endfunction
    function automatic logic [1:0] get_trap(input int w);
        return (w == 32) ? trap32 : trap64;
    endfunction

    task automatic set_valid(input int w, input logic v);
        v32 = (w == 32) && v;
        v64 = (w == 64) && v;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Divider latency for a non-trapping divide whose dividend magnitude has sig significant bits.
    function automatic int dl(input int w, input int sig);
`ifdef WASM_ALU_DIV_EARLY_OUT_EN
        return (sig == 0) ? 1 : 1 + sig;
`else
        return 1 + w;
`endif
    endfunction

    function automatic void ref_model(input int w, input alu_op_t o, input logic [63:0] ia, input logic [63:0] ib,
                                      output logic [63:0] r, output logic [1:0] t, output int lat);
        logic [63:0] mask, ua, ub, mn, mag;
        longint      sa, sb;
        int          s, n, sig;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        ua   = ia & mask;
        ub   = ib & mask;
        sa   = (w == 64) ? longint'(ua) : longint'(signed'(ua[31:0]));
        sb   = (w == 64) ? longint'(ub) : longint'(signed'(ub[31:0]));
        s    = int'(ub % 64'(w));
        mn   = 64'd1 << (w - 1);
        r    = 64'd0;
        t    = 2'd0;
        lat  = 1;
        mag  = ((o == OP_DIV_S || o == OP_REM_S) && sa < 0) ? 64'(-sa) : ua;
        sig  = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) sig = i + 1;
`ifdef WASM_ALU_DIV_EARLY_OUT_EN
        if ((o == OP_DIV_U || o == OP_REM_U) && ua < ub) sig = 0;
`endif
        case (o)
            OP_ADD:    r = ua + ub;
            OP_SUB:    r = ua - ub;
            OP_MUL:    r = ua * ub;
            OP_DIV_S, OP_REM_S: begin
                if (ub == 0) t = 2'd1;
                else if (ua == mn && ub == mask) begin
                    if (o == OP_DIV_S) t = 2'd2;
                end else begin
                    r   = (o == OP_DIV_S) ? 64'(sa / sb) : 64'(sa % sb);
                    lat = dl(w, sig);
                end
            end
            OP_DIV_U, OP_REM_U: begin
                if (ub == 0) t = 2'd1;
                else begin
                    r   = (o == OP_DIV_U) ? ua / ub : ua % ub;
                    lat = dl(w, sig);
                end
            end
            OP_AND:    r = ua & ub;
            OP_OR:     r = ua | ub;
            OP_XOR:    r = ua ^ ub;
            OP_SHL:    r = ua << s;
            OP_SHR_S:  r = 64'(sa >>> s);
            OP_SHR_U:  r = ua >> s;
            OP_ROTL:   r = (ua << s) | (ua >> (w - s));
            OP_ROTR:   r = (ua >> s) | (ua << (w - s));
            OP_CLZ: begin
                n = 0;
                for (int i = w - 1; i >= 0; i--) begin if (ua[i]) break; n++; end
                r = 64'(n);
            end
            OP_CTZ: begin
                n = 0;
                for (int i = 0; i < w; i++) begin if (ua[i]) break; n++; end
                r = 64'(n);
            end
            OP_POPCNT: r = 64'($countones(ua));
            OP_EQZ:    r = (ua == 0) ? 1 : 0;
            OP_EQ:     r = (ua == ub) ? 1 : 0;
            OP_NE:     r = (ua != ub) ? 1 : 0;
            OP_LT_S:   r = (sa < sb) ? 1 : 0;
            OP_LT_U:   r = (ua < ub) ? 1 : 0;
            OP_GT_S:   r = (sa > sb) ? 1 : 0;
            OP_GT_U:   r = (ua > ub) ? 1 : 0;
            OP_LE_S:   r = (sa <= sb) ? 1 : 0;
            OP_LE_U:   r = (ua <= ub) ? 1 : 0;
            OP_GE_S:   r = (sa >= sb) ? 1 : 0;
            OP_GE_U:   r = (ua >= ub) ? 1 : 0;
            default:   r = 64'd0;
        endcase
        r = r & mask;
    endfunction

    task automatic run_op(input int w, input alu_op_t o, input logic [63:0] oa, input logic [63:0] ob,
                          output logic [63:0] r, output logic [1:0] t, output int lat, output int bsy);
        int guard;
        @(negedge clk);
        op = o; a = oa; b = ob;
        set_valid(w, 1'b1);
        guard = 0;
        while (!get_ri(w) && guard < 200) begin @(negedge clk); guard++; end
        @(negedge clk);
        set_valid(w, 1'b0);
        lat = 1;
        bsy = 0;
        while (!get_vo(w) && lat < 200) begin
            if (get_busy(w)) bsy++;
            @(negedge clk);
            lat++;
        end
        r = get_res(w);
        t = get_trap(w);
    endtask

    typedef struct {
        int          w;
        alu_op_t     op;
        logic [63:0] a, b, r;
        logic [1:0]  t;
        int          lat;
    } vec_t;

    vec_t        vt[$];
    logic [63:0] gr, er;
    logic [1:0]  gt, et;
    int          gl, el, gb, seen;

    initial begin
        rst_n = 1'b0; flush = 1'b0; ready_out = 1'b1;
        v32 = 1'b0; v64 = 1'b0; op = OP_ADD; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst vo32", vo32, 0);   chk("rst res32", res32, 0);  chk("rst trap32", trap32, 0);
        chk("rst busy32", busy32, 0); chk("rst ri32", ri32, 1);
        chk("rst vo64", vo64, 0);   chk("rst res64", res64, 0);  chk("rst busy64", busy64, 0);
        rst_n = 1'b1;

        vt.push_back('{32, OP_ADD,    64'hFFFF_FFFF, 64'd1, 64'd0, 2'd0, 1});
        vt.push_back('{32, OP_DIV_S,  64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 2'd0, dl(32, 3)});
        vt.push_back('{32, OP_REM_S,  64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 2'd0, dl(32, 3)});
        vt.push_back('{64, OP_DIV_S,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'd2, 1});
        vt.push_back('{64, OP_REM_U,  64'd5, 64'd0, 64'd0, 2'd1, 1});
        vt.push_back('{64, OP_SHL,    64'd1, 64'd65, 64'd2, 2'd0, 1});
        vt.push_back('{64, OP_ROTR,   64'd1, 64'd1, 64'h8000_0000_0000_0000, 2'd0, 1});
        vt.push_back('{64, OP_CLZ,    64'd0, 64'd0, 64'd64, 2'd0, 1});
        vt.push_back('{64, OP_POPCNT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd64, 2'd0, 1});
        vt.push_back('{64, OP_REM_S,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'd0, 1});
        vt.push_back('{32, alu_op_t'(5'd30), 64'd7, 64'd9, 64'd0, 2'd0, 1});
        vt.push_back('{32, OP_CTZ,    64'd0, 64'd0, 64'd32, 2'd0, 1});
        vt.push_back('{32, OP_DIV_U,  64'd10, 64'd3, 64'd3, 2'd0, dl(32, 4)});
`ifdef WASM_ALU_DIV_EARLY_OUT_EN
        vt.push_back('{32, OP_DIV_U,  64'd3, 64'd10, 64'd0, 2'd0, 1});
`else
        vt.push_back('{32, OP_DIV_U,  64'd3, 64'd10, 64'd0, 2'd0, 33});
`endif
        vt.push_back('{64, OP_LT_S,   64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 2'd0, 1});
        vt.push_back('{32, OP_SHR_S,  64'h8000_0000, 64'd63, 64'hFFFF_FFFF, 2'd0, 1});
        vt.push_back('{32, OP_ROTL,   64'h8000_0001, 64'd4, 64'h0000_0018, 2'd0, 1});

        foreach (vt[i]) begin
            run_op(vt[i].w, vt[i].op, vt[i].a, vt[i].b, gr, gt, gl, gb);
            chk($sformatf("vec%0d result", i), gr, vt[i].r);
            chk($sformatf("vec%0d trap", i), 64'(gt), 64'(vt[i].t));
            chk($sformatf("vec%0d latency", i), 64'(gl), 64'(vt[i].lat));
            chk($sformatf("vec%0d busy cycles", i), 64'(gb), 64'(vt[i].lat - 1));
        end

        // Back-to-back: SUB accepted in the cycle the ADD result drains.
        @(negedge clk);
        op = OP_ADD; a = 64'hFFFF_FFFF; b = 64'd1; set_valid(32, 1'b1);
        @(negedge clk);
        chk("b2b add valid", vo32, 1); chk("b2b add result", res32, 0); chk("b2b ready", ri32, 1);
        op = OP_SUB; a = 64'd5; b = 64'd7;
        @(negedge clk);
        set_valid(32, 1'b0);
        chk("b2b sub valid", vo32, 1); chk("b2b sub result", res32, 32'hFFFF_FFFE);
        @(negedge clk);
        chk("b2b drained", vo32, 0);

        // Result held while the consumer stalls; a waiting request is not taken.
        ready_out = 1'b0;
        op = OP_MUL; a = 64'd3; b = 64'd4; set_valid(32, 1'b1);
        @(negedge clk);
        op = OP_ADD; a = 64'd1; b = 64'd1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d valid", k), vo32, 1);
            chk($sformatf("hold%0d result", k), res32, 12);
            chk($sformatf("hold%0d trap", k), trap32, 0);
            chk($sformatf("hold%0d ready_in", k), ri32, 0);
        end
        ready_out = 1'b1;
        @(negedge clk);
        set_valid(32, 1'b0);
        chk("hold next result", res32, 2); chk("hold next valid", vo32, 1);
        @(negedge clk);
        chk("hold drained", vo32, 0);

        // Flush during a 64-bit divide, with a request presented in the flush cycle.
        op = OP_DIV_U; a = 64'hFFFF_0000_1234_5678; b = 64'd3; set_valid(64, 1'b1);
        @(negedge clk);
        set_valid(64, 1'b0);
        repeat (10) @(negedge clk);
        chk("flush busy before", busy64, 1);
        flush = 1'b1; op = OP_ADD; a = 64'd1; b = 64'd2; set_valid(64, 1'b1);
        @(negedge clk);
        flush = 1'b0; set_valid(64, 1'b0);
        chk("flush valid", vo64, 0); chk("flush busy", busy64, 0); chk("flush ready_in", ri64, 1);
        seen = 0;
        repeat (80) begin @(negedge clk); if (vo64) seen++; end
        chk("flush no output", 64'(seen), 0);

        // Asynchronous reset during a divide.
        op = OP_DIV_S; a = 64'hFFFF_0000_1234_5678; b = 64'd7; set_valid(64, 1'b1);
        @(negedge clk);
        set_valid(64, 1'b0);
        repeat (5) @(negedge clk);
        chk("rstdiv busy before", busy64, 1);
        rst_n = 1'b0;
        #1;
        chk("rstdiv valid", vo64, 0); chk("rstdiv result", res64, 0);
        chk("rstdiv trap", trap64, 0); chk("rstdiv busy", busy64, 0);
        chk("rstdiv res32", res32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (80) begin @(negedge clk); if (vo64) seen++; end
        chk("rstdiv no output", 64'(seen), 0);

        // Randomised operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            int          w, k;
            alu_op_t     o;
            logic [63:0] ra, rb, mn;
            w  = ($urandom_range(0, 1) == 0) ? 32 : 64;
            o  = alu_op_t'(5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) o = alu_op_t'(5'($urandom_range(3, 6)));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            mn = 64'd1 << (w - 1);
            k  = $urandom_range(0, 7);
            case (k)
                0: rb = 64'd0;
                1: rb = 64'($urandom_range(0, 20));
                2: ra = mn;
                3: begin ra = mn; rb = '1; end
                4: ra = 64'($urandom_range(0, 50));
                default: ;
            endcase
            ref_model(w, o, ra, rb, er, et, el);
            run_op(w, o, ra, rb, gr, gt, gl, gb);
            chk($sformatf("rnd%0d w%0d op%0d result", i, w, o), gr, er);
            chk($sformatf("rnd%0d w%0d op%0d trap", i, w, o), 64'(gt), 64'(et));
            chk($sformatf("rnd%0d w%0d op%0d latency", i, w, o), 64'(gl), 64'(el));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wasm_alu_int_mc.md
Name: wasm_alu_int_mc

Overview:
Width-parametrised WebAssembly integer ALU covering i32 and i64, with registered outputs and a valid/ready handshake on both sides.
- Single-cycle ops (arith, bitwise, shift, rotate, count, compare) complete in 1 cycle.
- div/rem ops run on an iterative radix-2 restoring divider, one quotient bit per cycle.
- Sits in the execute stage between operand-stack read and writeback; replaces combinational divide to close timing at 64 bits.

Parameters:
WIDTH, 32, operand/result width; legal values 32 or 64.
CNT_W, $clog2(WIDTH)+1, divider iteration counter width; derived, not overridden.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of any in-flight op
valid_in  input  1  operation request valid
ready_in  output  1  ALU can accept a request this cycle
op  input  alu_op_t  operation select (wasm_pkg)
operand_a  input  WIDTH  first operand (lhs / unary source)
operand_b  input  WIDTH  second operand (rhs / shift amount)
valid_out  output  1  result/trap valid
ready_out  input  1  consumer accepts result
result  output  WIDTH  result value
trap  output  trap_t  TRAP_NONE / TRAP_INT_DIV_ZERO / TRAP_INT_OVERFLOW
busy  output  1  divider iterating

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, valid_out=0, result=0, trap=TRAP_NONE, busy=0, counter=0.
- Reset mid-divide: abandons the op immediately; nothing is emitted.
- States:
  - IDLE: no result held.
  - DIV: iterating.
  - DONE: valid_out=1, result and trap held stable until ready_out.
- ready_in = (state==IDLE) || (state==DONE && ready_out). A new op may be accepted in the same cycle the held result drains, giving throughput of 1 op/cycle for single-cycle ops.
- Accept = valid_in && ready_in.
- Single-cycle op accepted in cycle N: result/trap registered; DONE with valid_out=1 in cycle N+1.
- Divider ops (DIV_S/DIV_U/REM_S/REM_U):
  - If b==0: trap=TRAP_INT_DIV_ZERO, result=0, DONE at N+1.
  - If DIV_S and a==MIN_INT and b==all-ones: trap=TRAP_INT_OVERFLOW, result=0, DONE at N+1.
  - REM_S with MIN_INT, -1: no trap, result=0.
  - Otherwise: go to DIV; busy=1; counter loads WIDTH and decrements once per cycle; enter DONE when it reaches 0. valid_out asserts at N+1+WIDTH.
  - Signed ops: divide on magnitudes. Quotient is negated iff operand signs differ; remainder takes the sign of the dividend (truncating semantics).
- Shift/rotate amount = operand_b mod WIDTH, i.e. low $clog2(WIDTH) bits.
- CLZ/CTZ/POPCNT: count 0..WIDTH, zero-extended to WIDTH. CLZ(0)=CTZ(0)=WIDTH.
- Compare/EQZ: result is 0 or 1, zero-extended.
- ADD/SUB/MUL wrap modulo 2^WIDTH; MUL keeps the low WIDTH bits.
- Unknown op: result 0, TRAP_NONE, 1-cycle.
- Operands and op are latched at accept; input changes afterwards have no effect.
- DONE with ready_out=0: outputs frozen, ready_in=0.
- flush has priority over accept and over completion. Next cycle: state=IDLE, valid_out=0, busy=0. The op presented in the flush cycle is not accepted.

Optional Feature:
WASM_ALU_DIV_EARLY_OUT_EN.
- Defined: for an unsigned div/rem where |a| < |b| (magnitudes), skip DIV. Quotient=0, remainder=a (sign-corrected); DONE at N+1.
- Also defined: the divider skips leading-zero iterations of the dividend magnitude, so latency is 1 + (significant bits of |a|).
- Undefined: fixed latency of 1+WIDTH for every non-trapping divide.

Test Plan:
- WIDTH=32, ADD a=0xFFFFFFFF b=1, ready_out=1 -> valid_out at N+1, result=0, trap=NONE; back-to-back SUB accepted at N+1 -> result at N+2.
- WIDTH=32, DIV_S a=-7 b=2 -> busy for 32 cycles, valid_out at N+33, result=0xFFFFFFFD; REM_S same operands -> 0xFFFFFFFF.
- WIDTH=64, DIV_S a=0x8000000000000000 b=-1 -> trap=TRAP_INT_OVERFLOW at N+1; REM_U b=0 -> TRAP_INT_DIV_ZERO, result 0.
- WIDTH=64: SHL a=1 b=65 -> 2; ROTR a=1 b=1 -> 0x8000000000000000; CLZ a=0 -> 64; POPCNT all-ones -> 64.
- DIV_U in flight at iteration 10: assert flush -> valid_out stays 0, ready_in=1 next cycle. Repeat with rst_n low mid-divide -> all outputs at reset values.
- Result held with ready_out=0 for 5 cycles -> result/trap stable, ready_in=0. Early-out build: DIV_U 3/10 -> result 0 at N+1.
